// File: rtl/fifo_overflow_mw.sv
// Multi-lane FIFO with W push/pop lanes per cycle, one-cycle write latency and
// selectable overflow policy (overwrite oldest or reject newest) with drop accounting.
module fifo_overflow_mw #(
   parameter int unsigned DW        = 16,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned W         = 2,
   parameter int unsigned OVERWRITE = 1,
   parameter int unsigned CW        = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [$clog2(W+1)-1:0]       push_cnt,
   input  logic [W*DW-1:0]              push_data,
   input  logic [$clog2(W+1)-1:0]       pop_cnt,
   output logic [W*DW-1:0]              pop_data,
   output logic [W-1:0]                 valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [$clog2(DEPTH+1)-1:0]   free,
   output logic                         empty,
   output logic                         full,
   output logic                         ovf,
   output logic [CW-1:0]                drop_cnt
);

   localparam int unsigned OW = $clog2(DEPTH+1);
   localparam int unsigned PW = $clog2(DEPTH);
   // One spare bit so pointer sums up to 2*DEPTH-1 do not overflow.
   localparam int unsigned LW = OW + 1;
   localparam logic [LW-1:0] DepthL = LW'(DEPTH);
   localparam logic [LW-1:0] WL     = LW'(W);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0] count_q, count_d;
   logic [CW-1:0] drop_q, drop_d;
   logic          ovf_q, ovf_d;

   logic [LW-1:0] cnt_l, pop_l, push_l, p, n, space, over, ex, wr_num;
   logic [CW:0]   drop_sum;

   // Arguments are always below 2*DEPTH, so one conditional subtract wraps.
   function automatic logic [PW-1:0] wrap(input logic [LW-1:0] s);
      return PW'((s >= DepthL) ? s - DepthL : s);
   endfunction

   always_comb begin
      cnt_l  = LW'(count_q);
      pop_l  = LW'(pop_cnt);
      push_l = LW'(push_cnt);
      p      = (pop_l < cnt_l) ? pop_l : cnt_l;
      n      = (push_l < WL) ? push_l : WL;
      space  = DepthL - cnt_l + p;
      over   = (n > space) ? n - space : '0;
      if (OVERWRITE != 0) begin
         wr_num = n;
         ex     = over;
      end else begin
         wr_num = n - over;
         ex     = '0;
      end
      drop_sum = {1'b0, drop_q} + (CW+1)'(over);

      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      drop_d  = drop_q;
      ovf_d   = 1'b0;

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < W; i++) begin
            if (LW'(i) < wr_num) begin
               mem_d[wrap(LW'(tail_q) + LW'(i))] = push_data[i*DW +: DW];
            end
         end
         head_d  = wrap(LW'(head_q) + p + ex);
         tail_d  = wrap(LW'(tail_q) + wr_num);
         count_d = OW'(cnt_l - p + wr_num - ex);
         drop_d  = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
         ovf_d   = (over != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage is deliberately left out of reset; valid masks stale contents.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int i = 0; i < W; i++) begin
         pop_data[i*DW +: DW] = mem_q[wrap(LW'(head_q) + LW'(i))];
         valid[i]             = (LW'(count_q) > LW'(i));
      end
   end

   assign count    = count_q;
   assign free     = OW'(DEPTH) - count_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == OW'(DEPTH));
   assign ovf      = ovf_q;
   assign drop_cnt = drop_q;

endmodule
